// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width helper for the bit-serial adder
//
// Contents:
//   state_t           FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
//   cnt_width(width)  bit-counter width for a given operand width, i.e. $clog2(width)

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - single-bit full-adder cell
//
// Ports:
//   a, b   in   operand bits
//   c_in   in   carry in
//   y      out  sum bit
//   c_out  out  carry out

module serial_adder_ctrl_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic y,
    output logic c_out
);

    assign y     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, one bit per clock, LSB first
//
// Parameters:
//   WIDTH   operand/result width (>= 2)
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   add request, sampled in IDLE or DONE only
//   a, b    in   operands, captured on the accepting edge
//   c_in    in   carry-in, captured on the accepting edge
//   busy    out  high while the add is in progress
//   done    out  one-cycle pulse when sum/c_out/ovf are fresh
//   sum     out  result modulo 2^WIDTH, held until the next completion
//   c_out   out  carry out of the MSB
//   ovf     out  two's-complement overflow

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sh_a_q,   sh_a_d;
    logic [WIDTH-1:0] sh_b_q,   sh_b_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_out_q,  c_out_d;
    logic             ovf_q,    ovf_d;

    logic fa_y;
    logic fa_co;

    serial_adder_ctrl_full_adder u_fa (
        .a     (sh_a_q[0]),
        .b     (sh_b_q[0]),
        .c_in  (carry_q),
        .y     (fa_y),
        .c_out (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_RUN: begin
                // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                sum_sh_d = (sum_sh_q >> 1) | {fa_y, {(WIDTH-1){1'b0}}};
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                carry_d  = fa_co;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_sh_d;
                    c_out_d = fa_co;
                    // carry_q is the carry into the MSB on this last step.
                    ovf_d   = carry_q ^ fa_co;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            // IDLE, DONE and the unused encoding all behave as "ready for start".
            default: begin
                busy_d = 1'b0;
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard testbench for serial_adder_ctrl

module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            check("done_busy_overlap", int'(busy), 0);
            check("done_consecutive", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: sum=0x%0h with empty scoreboard", sum);
            end else begin
                e = exp_q.pop_front();
                check("sum", int'(sum), int'(e.sum));
                check("c_out", int'(c_out), int'(e.co));
                check("ovf", int'(ovf), int'(e.ovf));
            end
        end
        prev_done <= done;
    end

    // Counts edges until done is seen; also counts how many of those samples had busy high.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy && !done) nbusy++;
        end while (!done && n < 40);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum = s;
        e.co  = co;
        e.ovf = ov;
        exp_q.push_back(e);
    endtask

    task automatic add_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es,
                          input logic eco, input logic eov);
        int n, nb;
        a = av;
        b = bv;
        c_in = cv;
        start = 1'b1;
        push_exp(es, eco, eov);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        wait_done(n, nb);
        check("latency", n, WIDTH);
        check("busy_cycles", nb, WIDTH - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, nb;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_c_out", int'(c_out), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        add_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        add_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        add_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        add_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        add_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        add_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        add_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        add_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // start pulse in the middle of a run must be ignored
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        push_exp(8'h30, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        check("ignored_start_remaining", n, WIDTH - 4);
        repeat (12) @(posedge clk);
        #1;
        check("ignored_start_sum_held", int'(sum), 8'h30);

        // start held high: back-to-back adds, one every WIDTH+1 cycles
        a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
        push_exp(8'h03, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a = 8'hF0; b = 8'h20; c_in = 1'b1;
        push_exp(8'h11, 1'b1, 1'b0);
        wait_done(n, nb);
        check("b2b_latency0", n, WIDTH);
        @(posedge clk);
        #1;
        check("b2b_reaccept_busy", int'(busy), 1);
        a = 8'h40; b = 8'h40; c_in = 1'b0;
        push_exp(8'h80, 1'b0, 1'b1);
        wait_done(n, nb);
        check("b2b_period1", n + 1, WIDTH + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        check("b2b_period2", n + 1, WIDTH + 1);
        @(posedge clk);
        #1;
        check("b2b_idle_after", int'(busy), 0);

        // reset in the middle of a run discards the operation
        a = 8'h55; b = 8'h11; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_sum", int'(sum), 0);
        check("midrst_c_out", int'(c_out), 0);
        check("midrst_ovf", int'(ovf), 0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done_busy", int'(busy), 0);
        add_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
